// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared snooping bus (4 L1 requesters).
// Optional watchdog: define ARB_TIMEOUT_EN to build the grant timeout.
module bus_arbiter #(
    parameter int NUM_CORES      = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_CORES-1:0] req,
    input  logic [NUM_CORES-1:0] wr,
    input  logic [2:0]           addr0,
    input  logic [2:0]           addr1,
    input  logic [2:0]           addr2,
    input  logic [2:0]           addr3,
    input  logic                 done,
    output logic [NUM_CORES-1:0] gnt,
    output logic [1:0]           gnt_id,
    output logic                 gnt_valid,
    output logic [2:0]           bus_addr,
    output logic                 bus_wr,
    output logic                 timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_RELEASE
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           ptr_q, ptr_d;
    logic [NUM_CORES-1:0] gnt_q, gnt_d;
    logic [1:0]           id_q, id_d;
    logic                 valid_q, valid_d;
    logic [2:0]           addr_q, addr_d;
    logic                 wr_q, wr_d;
    logic                 timeout_hit;

    logic                 win_found;
    logic [1:0]           win_id;
    logic [2:0]           win_addr;

`ifdef ARB_TIMEOUT_EN
    localparam logic [3:0] TO_LIM = 4'(TIMEOUT_CYCLES);

    logic [3:0] cnt_q, cnt_d;
    logic       terr_q;

    // Watchdog count: zero outside GRANT, so it starts from 0 on entry.
    always_comb begin
        cnt_d = 4'd0;
        if (state_q == S_GRANT) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    assign timeout_hit = (state_q == S_GRANT) && (cnt_d == TO_LIM);

    // Watchdog counter and one-cycle error pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 4'd0;
            terr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            terr_q <= timeout_hit && !done;
        end
    end

    assign timeout_err = terr_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Rotating priority search starting at ptr; first set request wins.
    always_comb begin
        logic [1:0] idx;
        win_found = 1'b0;
        win_id    = ptr_q;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    // Address of the selected winner.
    always_comb begin
        unique case (win_id)
            2'd0:    win_addr = addr0;
            2'd1:    win_addr = addr1;
            2'd2:    win_addr = addr2;
            default: win_addr = addr3;
        endcase
    end

    // Next-state and registered-output values.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d        = S_GRANT;
                    gnt_d          = '0;
                    gnt_d[win_id]  = 1'b1;
                    id_d           = win_id;
                    valid_d        = 1'b1;
                    addr_d         = win_addr;
                    wr_d           = wr[win_id];
                    ptr_d          = win_id + 2'd1;
                end
            end
            S_GRANT: begin
                if (done || timeout_hit) begin
                    state_d = S_RELEASE;
                    gnt_d   = '0;
                    id_d    = 2'd0;
                    valid_d = 1'b0;
                    addr_d  = 3'd0;
                    wr_d    = 1'b0;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, pointer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= 2'd0;
            gnt_q   <= '0;
            id_q    <= 2'd0;
            valid_q <= 1'b0;
            addr_q  <= 3'd0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = id_q;
    assign gnt_valid = valid_q;
    assign bus_addr  = addr_q;
    assign bus_wr    = wr_q;

endmodule
